// File: rtl/rice_bus_pkg.sv
// Shared constants and the response record used on the rice request/response bus.
package rice_bus_pkg;

  localparam int RICE_BUS_ADDRESS_WIDTH = 64;
  localparam int RICE_BUS_DATA_WIDTH    = 64;
  localparam int RICE_BUS_STROBE_WIDTH  = 8;

  typedef struct packed {
    logic [RICE_BUS_DATA_WIDTH-1:0] read_data;
    logic                           error;
  } rice_bus_response;

endpackage

// File: rtl/rice_bus_memory_slave_if.sv
// Request/response handshake bundle between a rice bus master and the memory slave.
interface rice_bus_memory_slave_if
  import rice_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RICE_BUS_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = RICE_BUS_DATA_WIDTH
);

  logic                      o_request_ready;
  logic                      i_request_valid;
  logic [ADDRESS_WIDTH-1:0]  i_address;
  logic [DATA_WIDTH/8-1:0]   i_strobe;
  logic [DATA_WIDTH-1:0]     i_write_data;
  logic                      i_response_ready;
  logic                      o_response_valid;
  logic [DATA_WIDTH-1:0]     o_read_data;
  logic                      o_error;

  modport slave (
    output o_request_ready, o_response_valid, o_read_data, o_error,
    input  i_request_valid, i_address, i_strobe, i_write_data, i_response_ready
  );

  modport master (
    input  o_request_ready, o_response_valid, o_read_data, o_error,
    output i_request_valid, i_address, i_strobe, i_write_data, i_response_ready
  );

endinterface

// File: rtl/rice_bus_response_fifo.sv
// In-order response queue; outputs read as zero whenever the queue is empty.
module rice_bus_response_fifo
  import rice_bus_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  rice_bus_response i_push_data,
  input  logic             i_pop,
  output rice_bus_response o_pop_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  rice_bus_response mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (i_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (i_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({i_push, i_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == CNT_W'(DEPTH));
  assign o_count    = count_q;
  assign o_pop_data = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rice_bus_memory_slave.sv
// Word-addressed memory responder for the rice bus with an in-order response queue.
// Optional accept throttling is enabled by defining RICE_BUS_MEMORY_SLAVE_WAIT_EN.
module rice_bus_memory_slave
  import rice_bus_pkg::*;
#(
  parameter int          ADDRESS_WIDTH  = 64,
  parameter int          DATA_WIDTH     = 64,
  parameter int          DEPTH          = 1024,
  parameter logic [63:0] BASE_ADDRESS   = 64'h0,
  parameter int          RESPONSE_DEPTH = 2,
  parameter int          WAIT_CYCLES    = 2
) (
  input logic                    i_clk,
  input logic                    i_rst,
  rice_bus_memory_slave_if.slave bus
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(RESPONSE_DEPTH + 1);
  localparam logic [ADDRESS_WIDTH-1:0] MEM_BYTES = ADDRESS_WIDTH'(DEPTH * BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] BASE      = ADDRESS_WIDTH'(BASE_ADDRESS);

  logic                     ready_q;
  logic                     ready_d;
  logic                     accept;
  logic                     addr_error;
  logic                     is_read;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_BITS-1:0]      word_idx;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic                     wait_clear;

  rice_bus_response         push_data;
  rice_bus_response         pop_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W-1:0]         count_d;
  logic                     pop;

  assign accept   = bus.i_request_valid && ready_q;
  assign is_read  = (bus.i_strobe == '0);
  assign offset   = bus.i_address - BASE;
  assign word_idx = offset[OFF_BITS +: IDX_BITS];
  assign addr_error = !((bus.i_address >= BASE) && (offset < MEM_BYTES) &&
                        (bus.i_address[OFF_BITS-1:0] == '0));

  // One narrow array per byte lane so strobed writes map onto byte-enabled RAM.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (accept && !addr_error && bus.i_strobe[gi]) begin
        lane_mem[word_idx] <= bus.i_write_data[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
  end

  always_comb begin
    push_data           = '0;
    push_data.error     = addr_error;
    if (is_read && !addr_error) begin
      push_data.read_data = RICE_BUS_DATA_WIDTH'(rd_word);
    end
  end

  assign pop = !fifo_empty && bus.i_response_ready;

  rice_bus_response_fifo #(
    .DEPTH (RESPONSE_DEPTH)
  ) u_response_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (accept),
    .i_push_data (push_data),
    .i_pop       (pop),
    .o_pop_data  (pop_data),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  always_comb begin
    count_d = fifo_count;
    if (accept && !pop) begin
      count_d = fifo_count + 1'b1;
    end else if (!accept && pop) begin
      count_d = fifo_count - 1'b1;
    end
  end

`ifdef RICE_BUS_MEMORY_SLAVE_WAIT_EN
  localparam int WAIT_W = $clog2(WAIT_CYCLES + 2);

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  always_comb begin
    wait_d = wait_q;
    if (accept) begin
      wait_d = WAIT_W'(WAIT_CYCLES);
    end else if (wait_q != '0) begin
      wait_d = wait_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wait_clear = (wait_d == '0);
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = |WAIT_CYCLES;
  assign wait_clear      = 1'b1;
`endif

  // Ready is registered from next-cycle occupancy so a full queue reopens one cycle after a pop.
  assign ready_d = (count_d < CNT_W'(RESPONSE_DEPTH)) && wait_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

  assign bus.o_request_ready  = ready_q;
  assign bus.o_response_valid = !fifo_empty;
  assign bus.o_read_data      = pop_data.read_data[DATA_WIDTH-1:0];
  assign bus.o_error          = pop_data.error;

endmodule
